// File: rtl/id_scoreboard.sv
// Register scoreboard for the ID stage: tracks in-flight register writes per
// architectural register and raises a combinational issue stall on RAW hazards or counter saturation.
module id_scoreboard #(
  parameter int unsigned REG_NUM = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned PERF_W  = 16
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      issue_valid,
  input  logic                      issue_RegWrite,
  input  logic [ADDR_W-1:0]         issue_WriteRegister,
  input  logic [NUM_SRC*ADDR_W-1:0] issue_src,
  input  logic [NUM_SRC-1:0]        issue_src_used,
  input  logic                      retire_valid,
  input  logic [ADDR_W-1:0]         retire_WriteRegister,
  output logic                      ID_stall,
  output logic [REG_NUM-1:0]        pending,
  output logic [PERF_W-1:0]         stall_count,
  output logic                      sb_error
);

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [PERF_W-1:0] PERF_MAX = '1;

  logic [CNT_W-1:0] cnt      [REG_NUM];
  logic [CNT_W-1:0] cnt_next [REG_NUM];
  logic             raw_hazard;
  logic             waw_hazard;
  logic             issue_accept;
  logic             retire_err;

  // Register 0 and addresses beyond REG_NUM are never tracked.
  function automatic logic addr_tracked(input logic [ADDR_W-1:0] a);
    logic hit;
    hit = 1'b0;
    for (int unsigned r = 1; r < REG_NUM; r++) begin
      if (a == ADDR_W'(r)) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_of(input logic [ADDR_W-1:0] a);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int unsigned r = 1; r < REG_NUM; r++) begin
      if (a == ADDR_W'(r)) c = cnt[r];
    end
    return c;
  endfunction

  // A source whose last outstanding write is retiring this cycle is bypassed from WB.
  function automatic logic src_hazard(input logic [ADDR_W-1:0] a);
    logic [CNT_W-1:0] c;
    c = cnt_of(a);
    return (c != '0) &&
           !((c == CNT_ONE) && retire_valid && (retire_WriteRegister == a));
  endfunction

  always_comb begin
    raw_hazard = 1'b0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (issue_src_used[k] && src_hazard(issue_src[k*ADDR_W +: ADDR_W])) raw_hazard = 1'b1;
    end
    waw_hazard = issue_RegWrite &&
                 (cnt_of(issue_WriteRegister) == CNT_MAX) &&
                 !(retire_valid && (retire_WriteRegister == issue_WriteRegister));
    ID_stall     = issue_valid && (raw_hazard || waw_hazard);
    issue_accept = issue_valid && !ID_stall && issue_RegWrite &&
                   addr_tracked(issue_WriteRegister);
    retire_err   = retire_valid && addr_tracked(retire_WriteRegister) &&
                   (cnt_of(retire_WriteRegister) == '0);
  end

  // Per-register counter update; a same-cycle issue and retire cancel out.
  always_comb begin
    for (int unsigned r = 0; r < REG_NUM; r++) begin
      logic inc;
      logic dec;
      cnt_next[r] = cnt[r];
      inc = issue_accept && (issue_WriteRegister == ADDR_W'(r));
      dec = retire_valid && (retire_WriteRegister == ADDR_W'(r));
      if (r == 0) begin
        cnt_next[r] = '0;
      end else if (inc && !dec) begin
        cnt_next[r] = cnt[r] + CNT_ONE;
      end else if (dec && !inc && (cnt[r] != '0)) begin
        cnt_next[r] = cnt[r] - CNT_ONE;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned r = 0; r < REG_NUM; r++) cnt[r] <= '0;
      pending     <= '0;
      stall_count <= '0;
      sb_error    <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < REG_NUM; r++) begin
        cnt[r]     <= cnt_next[r];
        pending[r] <= (r != 0) && (cnt_next[r] != '0);
      end
      if (ID_stall && (stall_count != PERF_MAX)) stall_count <= stall_count + PERF_W'(1);
      if (retire_err) sb_error <= 1'b1;
    end
  end

endmodule

// File: doc/id_scoreboard.md
ID_SCOREBOARD -- requirements
Module: id_scoreboard

Interface
REQ-001 Parameter REG_NUM, default 32, number of architectural registers tracked.
REQ-002 Parameter ADDR_W, default 5, register address width; REG_NUM SHALL be at most 2^ADDR_W.
REQ-003 Parameter NUM_SRC, default 2, number of source operands checked per decoded instruction.
REQ-004 Parameter CNT_W, default 2, width of the per-register in-flight write counter.
REQ-005 Parameter PERF_W, default 16, width of the stall-cycle performance counter.
REQ-006 Clk  input  1  single clock; all state updates on the rising edge.
REQ-007 Reset  input  1  synchronous reset, active-high.
REQ-008 issue_valid  input  1  the decoded instruction in ID is presented for issue.
REQ-009 issue_RegWrite  input  1  the issuing instruction writes a register.
REQ-010 issue_WriteRegister  input  ADDR_W  destination register of the issuing instruction.
REQ-011 issue_src  input  NUM_SRC*ADDR_W  packed source registers; source k is bits [k*ADDR_W +: ADDR_W].
REQ-012 issue_src_used  input  NUM_SRC  bit k set: source k is read by the instruction.
REQ-013 retire_valid  input  1  a register write is performed in WB this cycle.
REQ-014 retire_WriteRegister  input  ADDR_W  register written in WB.
REQ-015 ID_stall  output  1  combinational; the instruction in ID SHALL NOT issue this cycle.
REQ-016 pending  output  REG_NUM  registered; bit r set when the counter of register r is nonzero.
REQ-017 stall_count  output  PERF_W  registered count of cycles with issue_valid and ID_stall both high.
REQ-018 sb_error  output  1  registered, sticky; set on a retire to a register with a zero counter.

Function
REQ-019 Each register r in 1..REG_NUM-1 SHALL have a CNT_W-bit counter of issued-but-unretired writes; register 0 SHALL never be tracked, and its pending bit SHALL be constant 0.
REQ-020 RAW hazard: source k SHALL hazard when issue_src_used[k], its address is nonzero, and its counter is nonzero, except when the counter equals 1 and retire_valid targets the same register this cycle (WB-to-ID bypass).
REQ-021 WAW saturation: the destination SHALL hazard when issue_RegWrite, the address is nonzero, and its counter equals 2^CNT_W-1, unless a retire to that register occurs this cycle.
REQ-022 ID_stall SHALL equal issue_valid AND (any RAW hazard OR WAW saturation); ID_stall SHALL be 0 whenever issue_valid is 0.
REQ-023 Issue is accepted when issue_valid and not ID_stall; if issue_RegWrite and the destination is nonzero, that counter SHALL increment on the next edge.
REQ-024 A retire with a nonzero address and a nonzero counter SHALL decrement that counter on the next edge.
REQ-025 An accepted issue and a retire to the same register in one cycle SHALL leave that counter unchanged.
REQ-026 A retire to a register whose counter is zero SHALL leave the counter at 0 and set sb_error; retires to register 0 SHALL be ignored without error.
REQ-027 Addresses greater than or equal to REG_NUM SHALL be ignored for issue, retire, and hazard checks.
REQ-028 Counter updates SHALL become visible in pending and in the hazard logic one cycle after the edge (latency 1).
REQ-029 stall_count SHALL increment by 1 on each cycle with issue_valid and ID_stall high, and SHALL saturate at 2^PERF_W-1.

Reset
REQ-030 On Reset high at a rising edge, all counters, pending, stall_count, and sb_error SHALL be cleared to 0.
REQ-031 Reset SHALL take priority over a simultaneous issue or retire; in-flight writes SHALL be forgotten, and retires after reset to cleared registers SHALL follow REQ-026.
REQ-032 While Reset is high, ID_stall SHALL still evaluate combinationally against the current (pre-reset) counters.

Verification
REQ-033 Issue writing r5, then next cycle issue reading r5 with src_used=01 -> ID_stall=1 and pending[5]=1; retire r5 -> same-cycle ID_stall=0, and pending[5]=0 one cycle later.
REQ-034 Issue three writes to r7 (CNT_W=2), then a fourth write to r7 -> ID_stall=1 on the fourth; with a simultaneous retire r7 -> ID_stall=0, and the counter stays 3.
REQ-035 Issue reading r0 and writing r0 while retire r0 -> ID_stall=0, pending=0, sb_error=0.
REQ-036 Retire r9 with an empty scoreboard -> sb_error=1 next cycle and stays set until Reset; pending[9]=0.
REQ-037 Hold a hazard for 10 cycles -> stall_count=10; with PERF_W=3, 10 stall cycles -> stall_count=7.
REQ-038 Issue writes to r3 and r4, then assert Reset concurrent with a retire r3 -> all pending bits 0, sb_error=0; a later retire r4 -> sb_error=1.
